// File: rtl/vga_pkg.sv
// Shared VGA/framebuffer definitions used by image_stream_loader,
// vga_controller and memory: display geometry, pixel format and the
// loader state encoding.
package vga_pkg;

    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int ADDR_W       = 19;
    localparam int PIX_W        = 24;
    localparam int FRAME_PIXELS = H_RES * V_RES;

    // Two-byte sync marker expected ahead of pixel data when the header is enabled
    localparam logic [7:0] HDR_BYTE0 = 8'hA5;
    localparam logic [7:0] HDR_BYTE1 = 8'h5A;

    // HDR0/HDR1 are always declared so the encoding is identical in every build
    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        GET_R,
        GET_G,
        GET_B,
        WRITE,
        DONE
    } loader_state_t;

    typedef enum logic [1:0] {
        LANE_R = 2'd0,
        LANE_G = 2'd1,
        LANE_B = 2'd2
    } byte_lane_t;

endpackage

// File: rtl/pixel_packer.sv
// Byte-lane register that assembles one {R,G,B} pixel from three
// independently loaded bytes. Sequencing is owned by the loader FSM.
module pixel_packer
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  byte_lane_t  lane_sel,
    input  logic [7:0]  byte_in,
    input  logic        load,
    output logic [23:0] pixel
);

    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;
    logic [7:0] b_q, b_d;

    // Steer the incoming byte into the selected lane; other lanes keep their value
    always_comb begin
        r_d = r_q;
        g_d = g_q;
        b_d = b_q;
        if (load) begin
            case (lane_sel)
                LANE_R:  r_d = byte_in;
                LANE_G:  g_d = byte_in;
                LANE_B:  b_d = byte_in;
                default: ;
            endcase
        end
    end

    // Lane storage, cleared by the asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else begin
            r_q <= r_d;
            g_q <= g_d;
            b_q <= b_d;
        end
    end

    assign pixel = {r_q, g_q, b_q};

endmodule

// File: rtl/image_stream_loader.sv
// Streams R,G,B byte triples from a valid/ready source into the
// framebuffer write port in raster order starting at address 0.
// Optional: define IMAGE_LOADER_HEADER_EN to require the 0xA5,0x5A
// sync marker after start before any pixel bytes are taken.
module image_stream_loader #(
    parameter int H_RES  = vga_pkg::H_RES,
    parameter int V_RES  = vga_pkg::V_RES,
    parameter int ADDR_W = vga_pkg::ADDR_W,
    parameter int PIX_W  = vga_pkg::PIX_W
) (
    input  logic              clk_25,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              frame_done
);

    import vga_pkg::*;

    localparam int                FRAME_PX  = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PX - 1);

`ifdef IMAGE_LOADER_HEADER_EN
    localparam loader_state_t START_STATE = HDR0;
`else
    localparam loader_state_t START_STATE = GET_R;
`endif

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [PIX_W-1:0]  last_data_q, last_data_d;

    logic              xfer;
    logic              pack_load;
    byte_lane_t        pack_lane;
    logic [23:0]       pixel;

    pixel_packer u_packer (
        .clk      (clk_25),
        .rst      (rst),
        .lane_sel (pack_lane),
        .byte_in  (s_data),
        .load     (pack_load),
        .pixel    (pixel)
    );

    // Status outputs are pure decodes of the state register, so they never depend on s_valid
    always_comb begin
        s_ready    = (state_q == HDR0) || (state_q == HDR1) ||
                     (state_q == GET_R) || (state_q == GET_G) || (state_q == GET_B);
        wr_en      = (state_q == WRITE);
        busy       = (state_q != IDLE);
        frame_done = (state_q == DONE);
        wr_addr    = wr_en ? cnt_q : last_addr_q;
        wr_data    = wr_en ? PIX_W'(pixel) : last_data_q;
        xfer       = s_valid && s_ready;
    end

    // Next-state logic; start restarts from any state except WRITE, whose write must complete
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        pack_load   = 1'b0;
        pack_lane   = LANE_R;

        if (start && state_q != WRITE) begin
            state_d = START_STATE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: ;
`ifdef IMAGE_LOADER_HEADER_EN
                HDR0: begin
                    if (xfer && s_data == HDR_BYTE0) begin
                        state_d = HDR1;
                    end
                end
                HDR1: begin
                    if (xfer) begin
                        if (s_data == HDR_BYTE1) begin
                            state_d = GET_R;
                        end else if (s_data == HDR_BYTE0) begin
                            state_d = HDR1;
                        end else begin
                            state_d = HDR0;
                        end
                    end
                end
`endif
                GET_R: begin
                    if (xfer) begin
                        pack_load = 1'b1;
                        pack_lane = LANE_R;
                        state_d   = GET_G;
                    end
                end
                GET_G: begin
                    if (xfer) begin
                        pack_load = 1'b1;
                        pack_lane = LANE_G;
                        state_d   = GET_B;
                    end
                end
                GET_B: begin
                    if (xfer) begin
                        pack_load = 1'b1;
                        pack_lane = LANE_B;
                        state_d   = WRITE;
                    end
                end
                WRITE: begin
                    last_addr_d = cnt_q;
                    last_data_d = PIX_W'(pixel);
                    if (start) begin
                        state_d = START_STATE;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = GET_R;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, pixel counter and held write-port values
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
        end
    end

endmodule
